dcache_resp: RTL

DCACHE_RESP -- requirements
Module: dcache_resp

---
 rtl/dcache_resp.sv | 77 +++++++
 1 files changed

// File: rtl/dcache_resp.sv
// dcache_resp: single-port line store with registered, aligned and extended load responses
module dcache_resp #(
  parameter int CACHE_WIDTHE = 6,
  parameter int CACHE_DEEPTHE = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         iReqValid,
  output logic                         oReqReady,
  input  logic                         iWrEn,
  input  logic [CACHE_DEEPTHE-1:0]     iAddr,
  input  logic [2**CACHE_WIDTHE-1:0]   iWrData,
  input  logic [2**CACHE_WIDTHE-1:0]   iWrMask,
  input  logic [2:0]                   iOff,
  input  logic [2:0]                   iLdOp,
  output logic                         oRespValid,
  input  logic                         iRespReady,
  output logic [31:0]                  oRdData,
  output logic                         oErr
);
  localparam int W = 2**CACHE_WIDTHE;
  localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, RESP = 2'd2;
  logic [1:0] state, state_n;
  logic [W-1:0] mem [2**CACHE_DEEPTHE];
  logic [CACHE_DEEPTHE-1:0] addr_q;
  logic [2:0] off_q, op_q;
  logic [W-1:0] line;
  logic [31:0] word, data_n;
  logic [15:0] half;
  logic [7:0] bt;
  logic acc, ld_acc, err_n;
  assign oReqReady = (state == IDLE) | ((state == RESP) & iRespReady);
  assign acc = iReqValid & oReqReady;
  assign ld_acc = acc & ~iWrEn;
  assign state_n = ld_acc ? READ : (state == READ) ? RESP : ((state == RESP) & ~iRespReady) ? RESP : IDLE;
  always_comb begin
    line = mem[addr_q];
    word = line[{off_q[2], 5'd0} +: 32];
    half = word[{off_q[1], 4'd0} +: 16];
    bt = word[{off_q[1:0], 3'd0} +: 8];
    err_n = ~((op_q == 3'b000) | (op_q == 3'b100) |
              (((op_q == 3'b001) | (op_q == 3'b101)) & ~off_q[0]) |
              ((op_q == 3'b010) & (off_q[1:0] == 2'b00)));
    data_n = err_n ? 32'd0 :
             (op_q == 3'b000) ? {{24{bt[7]}}, bt} :
             (op_q == 3'b100) ? {24'd0, bt} :
             (op_q == 3'b001) ? {{16{half[15]}}, half} :
             (op_q == 3'b101) ? {16'd0, half} : word;
  end
  // storage is deliberately outside the reset domain
  always_ff @(posedge clk) begin
    if (acc & iWrEn) mem[iAddr] <= (mem[iAddr] & ~iWrMask) | (iWrData & iWrMask);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      oRespValid <= 1'b0;
      oRdData <= '0;
      oErr <= 1'b0;
      addr_q <= '0;
      off_q <= '0;
      op_q <= '0;
    end else begin
      if (ld_acc) begin
        addr_q <= iAddr;
        off_q <= iOff;
        op_q <= iLdOp;
      end
      if (state == READ) begin
        oRdData <= data_n;
        oErr <= err_n;
        oRespValid <= 1'b1;
      end else if ((state == RESP) & iRespReady) oRespValid <= 1'b0;
      state <= state_n;
    end
  end
endmodule
